// File: rtl/spi_frame_arbiter_if.sv
// Byte-stream handshake between the frame arbiter and a single-CS, multi-byte SPI master.
interface spi_frame_arbiter_if;
  logic [1:0] TX_Count;
  logic [7:0] TX_Byte;
  logic       TX_DV;
  logic       TX_Ready;
  logic       RX_DV;
  logic [7:0] RX_Byte;
  logic       SPI_CS_n;

  // master: arbiter side; slave: SPI master instance side
  modport master (output TX_Count, TX_Byte, TX_DV,
                  input  TX_Ready, RX_DV, RX_Byte, SPI_CS_n);
  modport slave  (input  TX_Count, TX_Byte, TX_DV,
                  output TX_Ready, RX_DV, RX_Byte, SPI_CS_n);
endinterface

// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter that shares one byte-wide SPI master between NUM_REQ requesters,
// sequencing each fixed-length frame MSB-first and collecting the MISO word.
module spi_frame_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned BYTES_PER_FRAME = 3,
  parameter int unsigned TIMEOUT_CLKS    = 4096
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst,
  input  logic [NUM_REQ-1:0]                 i_Req,
  input  logic [NUM_REQ*8*BYTES_PER_FRAME-1:0] i_Req_Data,
  output logic [NUM_REQ-1:0]                 o_Grant,
  output logic [NUM_REQ-1:0]                 o_Done,
  output logic                               o_Timeout,
  output logic                               o_Busy,
  output logic [8*BYTES_PER_FRAME-1:0]       o_RX_Word,
  spi_frame_arbiter_if.master                spi
);

  localparam int unsigned FW    = 8 * BYTES_PER_FRAME;
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BYTES_PER_FRAME + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, WAIT_CS} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   r_ptr, ptr_nxt;
  logic [PTR_W-1:0]   r_owner, owner_nxt;
  logic [FW-1:0]      r_shift, shift_nxt;
  logic [FW-1:0]      rx_nxt;
  logic [CNT_W-1:0]   r_cnt, cnt_nxt;
  logic               r_guard, guard_nxt;
  logic [TO_W-1:0]    r_wait, wait_nxt;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt;
  logic               timeout_nxt, busy_nxt;
  logic               r_tx_dv, tx_dv_nxt;
  logic [7:0]         r_tx_byte, tx_byte_nxt;

  logic               win_found_c;
  logic [PTR_W-1:0]   win_idx_c;
  logic [PTR_W-1:0]   cand_c;
  logic [FW-1:0]      frame_c;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= (PTR_W+1)'(NUM_REQ)) s = s - (PTR_W+1)'(NUM_REQ);
    return s[PTR_W-1:0];
  endfunction

  assign spi.TX_Count = 2'(BYTES_PER_FRAME);
  assign spi.TX_Byte  = r_tx_byte;
  assign spi.TX_DV    = r_tx_dv;

  // Upward search from r_ptr with wrap; the first active request wins
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = wrap_add(r_ptr, PTR_W'(i));
      if (!win_found_c && i_Req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
    frame_c = i_Req_Data[win_idx_c*FW +: FW];
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = r_ptr;
    owner_nxt   = r_owner;
    shift_nxt   = r_shift;
    rx_nxt      = o_RX_Word;
    cnt_nxt     = r_cnt;
    guard_nxt   = 1'b0;
    wait_nxt    = r_wait;
    grant_nxt   = '0;
    done_nxt    = '0;
    timeout_nxt = 1'b0;
    busy_nxt    = o_Busy;
    tx_dv_nxt   = 1'b0;
    tx_byte_nxt = r_tx_byte;

    // MISO bytes shift in from the LSB end, including on the WAIT_CS exit edge
    if (state != IDLE && spi.RX_DV) rx_nxt = {o_RX_Word[FW-9:0], spi.RX_Byte};

    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (win_found_c && spi.TX_Ready) begin
          owner_nxt              = win_idx_c;
          grant_nxt[win_idx_c]   = 1'b1;
          tx_dv_nxt              = 1'b1;
          tx_byte_nxt            = frame_c[FW-1 -: 8];
          shift_nxt              = {frame_c[FW-9:0], 8'h00};
          rx_nxt                 = '0;
          cnt_nxt                = CNT_W'(1);
          busy_nxt               = 1'b1;
          wait_nxt               = '0;
          guard_nxt              = 1'b1;
          state_nxt              = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (!r_guard && spi.TX_Ready) begin
          wait_nxt = '0;
          if (r_cnt < CNT_W'(BYTES_PER_FRAME)) begin
            tx_dv_nxt   = 1'b1;
            tx_byte_nxt = r_shift[FW-1 -: 8];
            shift_nxt   = {r_shift[FW-9:0], 8'h00};
            cnt_nxt     = r_cnt + CNT_W'(1);
            guard_nxt   = 1'b1;
          end else begin
            state_nxt = WAIT_CS;
          end
        end else if (r_wait == TO_W'(TIMEOUT_CLKS - 1)) begin
          timeout_nxt = 1'b1;
          ptr_nxt     = wrap_add(r_owner, PTR_W'(1));
          state_nxt   = IDLE;
        end else begin
          wait_nxt = r_wait + TO_W'(1);
        end
      end
      WAIT_CS: begin
        if (spi.SPI_CS_n && spi.TX_Ready) begin
          done_nxt[r_owner] = 1'b1;
          ptr_nxt           = wrap_add(r_owner, PTR_W'(1));
          state_nxt         = IDLE;
        end else if (r_wait == TO_W'(TIMEOUT_CLKS - 1)) begin
          timeout_nxt = 1'b1;
          ptr_nxt     = wrap_add(r_owner, PTR_W'(1));
          state_nxt   = IDLE;
        end else begin
          wait_nxt = r_wait + TO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_shift   <= '0;
      o_RX_Word <= '0;
      r_cnt     <= '0;
      r_guard   <= 1'b0;
      r_wait    <= '0;
      o_Grant   <= '0;
      o_Done    <= '0;
      o_Timeout <= 1'b0;
      o_Busy    <= 1'b0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= '0;
    end else begin
      state     <= state_nxt;
      r_ptr     <= ptr_nxt;
      r_owner   <= owner_nxt;
      r_shift   <= shift_nxt;
      o_RX_Word <= rx_nxt;
      r_cnt     <= cnt_nxt;
      r_guard   <= guard_nxt;
      r_wait    <= wait_nxt;
      o_Grant   <= grant_nxt;
      o_Done    <= done_nxt;
      o_Timeout <= timeout_nxt;
      o_Busy    <= busy_nxt;
      r_tx_dv   <= tx_dv_nxt;
      r_tx_byte <= tx_byte_nxt;
    end
  end

endmodule

// File: doc/spi_frame_arbiter.md
# spi_frame_arbiter

Round-robin arbiter and frame sequencer that shares one byte-wide SPI master (single-CS, multi-byte-per-CS type) between NUM_REQ requesters. Each requester presents a 24-bit frame. The block grants one requester at a time, splits the frame into bytes MSB-first, and paces the master's DV/Ready handshake. It waits for CS release, returns the word clocked in on MISO, and reports completion or timeout to the owner. It sits between the IRS configuration logic and the SPI master instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- BYTES_PER_FRAME, 3, bytes per CS assertion; frame width FW = 8*BYTES_PER_FRAME
- TIMEOUT_CLKS, 4096, max clocks spent waiting on the master per byte or per CS release
- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous, active-high reset
- i_Req  in  NUM_REQ  level request per requester
- i_Req_Data  in  NUM_REQ*FW  frame of requester k at bits [k*FW +: FW]
- o_Grant  out  NUM_REQ  one-hot, 1-cycle pulse: frame of that requester accepted
- o_Done  out  NUM_REQ  one-hot, 1-cycle pulse: frame of that requester finished
- o_Timeout  out  1  1-cycle pulse: frame aborted by timeout
- o_Busy  out  1  high from grant until the cycle after done or timeout
- o_RX_Word  out  FW  MISO word of the last completed frame; valid when o_Done pulses
- o_TX_Count  out  2  constant BYTES_PER_FRAME, to the master
- o_TX_Byte  out  8  byte to the master
- o_TX_DV  out  1  1-cycle byte-valid pulse to the master
- i_TX_Ready  in  1  master ready for next byte
- i_RX_DV  in  1  master received-byte strobe
- i_RX_Byte  in  8  master received byte
- i_SPI_CS_n  in  1  master chip select, monitored for end of frame

## Operation
- States: IDLE, WAIT_BYTE, WAIT_CS.
- IDLE:
  - If any i_Req is set and i_TX_Ready = 1, select the winner. The search starts at index r_ptr and moves upward with wrap-around; the first requester found wins.
  - On the next edge:
    - latch the winner's frame into the shift register and clear the RX word;
    - pulse o_Grant[winner];
    - pulse o_TX_DV with o_TX_Byte = frame[FW-1:FW-8];
    - set the byte counter to 1, set o_Busy = 1, and go to WAIT_BYTE.
- WAIT_BYTE:
  - The first cycle after each o_TX_DV is a guard cycle; i_TX_Ready is ignored during it.
  - After the guard, on i_TX_Ready = 1:
    - if byte counter < BYTES_PER_FRAME, pulse o_TX_DV with the next byte (MSB-first) and increment the counter;
    - otherwise go to WAIT_CS.
- WAIT_CS:
  - Exit when i_SPI_CS_n = 1 and i_TX_Ready = 1 in the same cycle.
  - On exit, pulse o_Done[owner], set r_ptr = owner+1 (mod NUM_REQ), and return to IDLE. o_Busy drops on the following edge.
- RX capture: in every non-IDLE state, each i_RX_DV shifts i_RX_Byte into the LSB end of o_RX_Word. After BYTES_PER_FRAME strobes, the first byte received occupies the MSBs.
- Timeout:
  - A wait counter clears on each o_TX_DV and on entry to WAIT_CS, and increments otherwise in WAIT_BYTE/WAIT_CS.
  - When it reaches TIMEOUT_CLKS-1: pulse o_Timeout, give no o_Done, advance r_ptr past the owner, and go to IDLE.
- Requests are sampled only in IDLE. i_Req_Data is sampled only on the grant edge. A requester may drop i_Req after its grant.
- A request still held after its own done is eligible again, but it is searched last.
- A requester that drops i_Req before it is granted is skipped with no side effects.

## Timing
- Reset (i_Rst = 1 at a clock edge):
  - outputs: o_Grant, o_Done, o_Timeout, o_Busy, o_TX_DV = 0; o_TX_Byte = 0; o_RX_Word = 0;
  - internal: r_ptr = 0, state IDLE, counters 0.
  - Reset mid-frame drops the frame silently; no done or timeout is issued.
- Grant latency: request seen in IDLE at edge N gives o_Grant and the first o_TX_DV at edge N+1, in the same cycle.
- Consecutive o_TX_DV pulses are at least 2 cycles apart. o_TX_DV is never asserted in IDLE or WAIT_CS.
- o_Done and o_Grant are never high in the same cycle.
- Minimum IDLE dwell between frames is 1 cycle. Master CS inactive time is enforced by the i_TX_Ready gate.
- Simultaneous events:
  - i_Req rising in the same cycle as o_Done for another requester is not seen until IDLE.
  - i_RX_DV coincident with the WAIT_CS exit is still captured before o_RX_Word is presented.

## Test plan
- Single frame: i_Req[1] = 1 with data 24'h123456; the master model echoes bytes 0xA1, 0xB2, 0xC3 -> one o_Grant[1]; o_TX_Byte sequence 0x12, 0x34, 0x56; o_Done[1] with o_RX_Word = 24'hA1B2C3; o_Busy low 1 cycle after done.
- Round-robin: i_Req = 4'b1111 held continuously -> grant order 0, 1, 2, 3, 0, 1; each frame is exactly 3 o_TX_DV pulses.
- Priority after wrap: r_ptr = 3, i_Req = 4'b1001 -> requester 3 is granted first, then requester 0.
- Timeout: the master model never raises i_TX_Ready after the first byte, with TIMEOUT_CLKS = 16 -> o_Timeout pulses 16 cycles after the guard-cycle start; no o_Done; next grant goes to owner+1.
- Reset mid-frame: assert i_Rst during the second byte -> all outputs 0 the next cycle, r_ptr = 0, no o_Done; a new request is granted normally afterwards.
- Ready gating: i_Req[2] = 1 while i_TX_Ready = 0 for 10 cycles -> no grant until the edge after i_TX_Ready rises.
